// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the multi-cycle load/store unit.
//   SZ_B/SZ_H/SZ_W/SZ_D  access-size encodings carried on req_size_i
//   lsu_state_t          FSM state encoding
//   be_mask()            byte-enable mask for a size at a lane offset
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    // Mask is always computed on 8 lanes; callers truncate to their lane count.
    // Only used for aligned accesses, so the shift never pushes bits off the top.
    function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] lanes;
        case (size)
            SZ_B:    lanes = 8'h01;
            SZ_H:    lanes = 8'h03;
            SZ_W:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        return lanes << offset;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data steering for the load/store unit.
//   st_size, st_wdata      store size and right-justified store data
//   st_data_pos            store data replicated so every enabled lane holds
//                          the right byte for any aligned offset
//   ld_size, ld_unsigned   load size and zero-extend select
//   ld_offset, ld_rdata    lane offset and raw memory word
//   ld_data_ext            extracted, sign/zero-extended load data
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NBYTES = XLEN / 8,
    parameter int OFFW   = $clog2(XLEN / 8)
) (
    input  logic [1:0]      st_size,
    input  logic [XLEN-1:0] st_wdata,
    output logic [XLEN-1:0] st_data_pos,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [OFFW-1:0] ld_offset,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data_ext
);

    logic [XLEN-1:0] shifted;

    // Replicating the access-sized chunk across all lanes equals the
    // offset shift on every enabled lane, since offsets are size-aligned.
    always_comb begin
        int lane_mask;
        lane_mask   = (1 << st_size) - 1;
        st_data_pos = '0;
        for (int i = 0; i < NBYTES; i++) begin
            st_data_pos[8*i +: 8] = st_wdata[8*(i & lane_mask) +: 8];
        end
    end

    always_comb begin
        int   nbits;
        logic fill;
        shifted = ld_rdata >> {ld_offset, 3'b000};
        nbits   = 8 << ld_size;
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        fill        = !ld_unsigned && shifted[nbits-1];
        ld_data_ext = '0;
        for (int b = 0; b < XLEN; b++) begin
            ld_data_ext[b] = (b < nbits) ? shifted[b] : fill;
        end
    end

endmodule

// File: rtl/lsu_mc.sv
// lsu_mc: handshaked multi-cycle load/store unit between the core and a
// variable-latency data memory.
//   clk, reset (async, active-low)
//   req_*   request from core, accepted in IDLE when req_ready_o is high
//   resp_*  one-cycle completion pulse with extended load data / error flag
//   dmem_*  registered memory request held until dmem_ack_i
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request; errors skip straight to RESP
// MEM     | memory request outstanding, all dmem_* held until ack
// RESP    | resp_valid_o for one cycle, then back to IDLE
module lsu_mc
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int NBYTES = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_err_o,
    output logic              dmem_req_o,
    output logic              dmem_w_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [NBYTES-1:0] dmem_be_o,
    output logic [XLEN-1:0]   dmem_w_data_o,
    input  logic              dmem_ack_i,
    input  logic [XLEN-1:0]   dmem_r_data_i
);

    localparam int OFFW = $clog2(NBYTES);

    lsu_state_t      state_q, state_d;
    logic            accept;
    logic            misaligned;
    logic            illegal_size;
    logic            req_err;
    logic [2:0]      req_off3;
    logic [XLEN-1:0] st_data_pos;
    logic [XLEN-1:0] ld_data_ext;

    logic            write_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [OFFW-1:0] off_q;
    logic            err_q;
    logic [XLEN-1:0] rdata_q;

    assign accept       = req_valid_i && req_ready_o;
    assign req_off3     = 3'(req_addr_i[OFFW-1:0]);
    assign misaligned   = ((req_size_i == SZ_H) && req_addr_i[0])
                        || ((req_size_i == SZ_W) && (|req_addr_i[1:0]))
                        || ((req_size_i == SZ_D) && (|req_addr_i[2:0]));
    assign illegal_size = (req_size_i == SZ_D) && (XLEN < 64);
    assign req_err      = misaligned || illegal_size;

    lsu_align #(
        .XLEN   (XLEN),
        .NBYTES (NBYTES),
        .OFFW   (OFFW)
    ) u_align (
        .st_size     (req_size_i),
        .st_wdata    (req_wdata_i),
        .st_data_pos (st_data_pos),
        .ld_size     (size_q),
        .ld_unsigned (unsigned_q),
        .ld_offset   (off_q),
        .ld_rdata    (dmem_r_data_i),
        .ld_data_ext (ld_data_ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = req_err ? ST_RESP : ST_MEM;
                end
            end
            ST_MEM: begin
                if (dmem_ack_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == ST_IDLE);
        resp_valid_o = (state_q == ST_RESP);
        resp_err_o   = (state_q == ST_RESP) && err_q;
    end

    // Request capture and memory-side registers. dmem_* are loaded only for
    // legal accesses so an error never disturbs the memory interface.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q       <= 1'b0;
            size_q        <= SZ_B;
            unsigned_q    <= 1'b0;
            off_q         <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            dmem_req_o    <= 1'b0;
            dmem_w_o      <= 1'b0;
            dmem_addr_o   <= '0;
            dmem_be_o     <= '0;
            dmem_w_data_o <= '0;
        end else begin
            if (accept) begin
                write_q    <= req_write_i;
                size_q     <= req_size_i;
                unsigned_q <= req_unsigned_i;
                off_q      <= req_addr_i[OFFW-1:0];
                err_q      <= req_err;
                rdata_q    <= '0;
                if (!req_err) begin
                    dmem_req_o    <= 1'b1;
                    dmem_w_o      <= req_write_i;
                    dmem_addr_o   <= {req_addr_i[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                    dmem_be_o     <= NBYTES'(be_mask(req_size_i, req_off3));
                    dmem_w_data_o <= st_data_pos;
                end
            end else if ((state_q == ST_MEM) && dmem_ack_i) begin
                dmem_req_o <= 1'b0;
                if (!write_q) begin
                    rdata_q <= ld_data_ext;
                end
            end
        end
    end

    assign resp_rdata_o = rdata_q;

endmodule
